// File: rtl/ext_bus_responder_pkg.sv
// rtl/ext_bus_responder_pkg.sv - shared state encoding and read-latency bounds for the external bus responder
package ext_bus_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CODE_WAIT,
        ST_CODE_DRIVE,
        ST_DATA_WAIT,
        ST_DATA_DRIVE,
        ST_WRITE_HOLD
    } bus_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef logic [1:0] lat_cnt_t;

    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/ext_bus_responder_bus_edge_sync.sv
// rtl/ext_bus_responder_bus_edge_sync.sv - registers the external bus once and derives strobe/ALE edges
module bus_edge_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       ale,
    input  logic       psen_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] p0_in,
    input  logic [7:0] p2_in,
    output logic       ale_r,
    output logic       psen_r,
    output logic       rd_r,
    output logic       wr_r,
    output logic [7:0] p0_r,
    output logic [7:0] p2_r,
    output logic       ale_fall,
    output logic       psen_fall,
    output logic       rd_fall,
    output logic       wr_fall,
    output logic       wr_rise
);

    logic ale_p;
    logic psen_p;
    logic rd_p;
    logic wr_p;

    // History resets to the inactive bus so reset release never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ale_r  <= 1'b0;
            psen_r <= 1'b1;
            rd_r   <= 1'b1;
            wr_r   <= 1'b1;
            ale_p  <= 1'b0;
            psen_p <= 1'b1;
            rd_p   <= 1'b1;
            wr_p   <= 1'b1;
            p0_r   <= 8'h00;
            p2_r   <= 8'h00;
        end else begin
            ale_r  <= ale;
            psen_r <= psen_n;
            rd_r   <= rd_n;
            wr_r   <= wr_n;
            ale_p  <= ale_r;
            psen_p <= psen_r;
            rd_p   <= rd_r;
            wr_p   <= wr_r;
            p0_r   <= p0_in;
            p2_r   <= p2_in;
        end
    end

    assign ale_fall  = ale_p & ~ale_r;
    assign psen_fall = psen_p & ~psen_r;
    assign rd_fall   = rd_p & ~rd_r;
    assign wr_fall   = wr_p & ~wr_r;
    assign wr_rise   = ~wr_p & wr_r;

endmodule

// File: rtl/ext_bus_responder.sv
// rtl/ext_bus_responder.sv - answers core code fetches and MOVX accesses from a backing memory
module ext_bus_responder
    import ext_bus_responder_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ale,
    input  logic        psen_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  p0_in,
    input  logic [7:0]  p2_in,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    output logic [15:0] mem_addr,
    output logic        code_rd,
    output logic        xdata_rd,
    output logic        xdata_wr,
    output logic [7:0]  xdata_wdata,
    input  logic [7:0]  code_rdata,
    input  logic [7:0]  xdata_rdata,
    output logic        bus_err
);

    localparam lat_cnt_t LAT = lat_cnt_t'(clamp_lat(RD_LAT));

    logic       ale_r, psen_r, rd_r, wr_r;
    logic [7:0] p0_r, p2_r;
    logic       ale_fall, psen_fall, rd_fall, wr_fall, wr_rise;

    bus_state_t  state, state_next;
    lat_cnt_t    wait_cnt;
    logic [15:0] ale_addr;
    logic        multi_low, err_set, drive;
    logic        issue_code, issue_data, issue_write, capture;

    bus_edge_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .ale       (ale),
        .psen_n    (psen_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .p0_in     (p0_in),
        .p2_in     (p2_in),
        .ale_r     (ale_r),
        .psen_r    (psen_r),
        .rd_r      (rd_r),
        .wr_r      (wr_r),
        .p0_r      (p0_r),
        .p2_r      (p2_r),
        .ale_fall  (ale_fall),
        .psen_fall (psen_fall),
        .rd_fall   (rd_fall),
        .wr_fall   (wr_fall),
        .wr_rise   (wr_rise)
    );

    assign multi_low = (~psen_r & ~rd_r) | (~psen_r & ~wr_r) | (~rd_r & ~wr_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next == state && (state == ST_CODE_WAIT || state == ST_DATA_WAIT))
                wait_cnt <= lat_cnt_t'(wait_cnt + 2'd1);
            else
                wait_cnt <= '0;
        end
    end

    // Protocol errors pre-empt every state; a released strobe during a wait wins over capture.
    always_comb begin
        state_next = state;
        if (multi_low || (state != ST_IDLE && ale_r)) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psen_fall)    state_next = ST_CODE_WAIT;
                    else if (rd_fall) state_next = ST_DATA_WAIT;
                    else if (wr_fall) state_next = ST_WRITE_HOLD;
                end
                ST_CODE_WAIT: begin
                    if (psen_r)               state_next = ST_IDLE;
                    else if (wait_cnt == LAT) state_next = ST_CODE_DRIVE;
                end
                ST_CODE_DRIVE: if (psen_r) state_next = ST_IDLE;
                ST_DATA_WAIT: begin
                    if (rd_r)                 state_next = ST_IDLE;
                    else if (wait_cnt == LAT) state_next = ST_DATA_DRIVE;
                end
                ST_DATA_DRIVE: if (rd_r) state_next = ST_IDLE;
                ST_WRITE_HOLD: if (wr_rise) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err_set     = multi_low | (state != ST_IDLE && ale_r);
        issue_code  = (state == ST_IDLE) && (state_next == ST_CODE_WAIT);
        issue_data  = (state == ST_IDLE) && (state_next == ST_DATA_WAIT);
        issue_write = (state == ST_WRITE_HOLD) && wr_rise && !err_set;
        capture     = (state == ST_CODE_WAIT && state_next == ST_CODE_DRIVE)
                    || (state == ST_DATA_WAIT && state_next == ST_DATA_DRIVE);
        drive       = (state == ST_CODE_DRIVE && !psen_r) || (state == ST_DATA_DRIVE && !rd_r);
        p0_oe       = drive && !ale_r && wr_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_addr    <= 16'h0000;
            mem_addr    <= 16'h0000;
            p0_out      <= 8'h00;
            xdata_wdata <= 8'h00;
            code_rd     <= 1'b0;
            xdata_rd    <= 1'b0;
            xdata_wr    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if (ale_r)    ale_addr <= {p2_r, p0_r};
            if (ale_fall) mem_addr <= ale_addr;
            if (!wr_r)    xdata_wdata <= p0_r;
            if (capture)  p0_out <= (state == ST_CODE_WAIT) ? code_rdata : xdata_rdata;
            code_rd  <= issue_code;
            xdata_rd <= issue_data;
            xdata_wr <= issue_write;
            if (err_set) bus_err <= 1'b1;
        end
    end

endmodule
